// File: rtl/puf_challenge_sequencer.sv
// Arbiter-PUF challenge sequencer: excites each LFSR challenge NVOTE times,
// majority-votes the synchronized response and hands it off via valid/ready.
module puf_challenge_sequencer #(
  parameter int                   C_LENGTH = 8,
  parameter int                   RESP_W   = 7,
  parameter int                   NVOTE    = 5,
  parameter int                   SETTLE   = 4,
  parameter logic [C_LENGTH-1:0]  SEED_RST = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                seed_load,
  input  logic [C_LENGTH-1:0] seed,
  output logic [C_LENGTH-1:0] ichallenge,
  output logic                opulse,
  input  logic [RESP_W-1:0]   iresponse,
  output logic [RESP_W-1:0]   oresp,
  output logic                ostable,
  output logic [C_LENGTH-1:0] ochal_tag,
  output logic                ovalid,
  input  logic                iready,
  output logic                busy
);

  typedef enum logic [2:0] {IDLE, ARM, FIRE, SAMPLE, RELAX, OUT} state_t;

  state_t              state_q, state_d;
  logic [3:0]          phase_q;
  logic [3:0]          vote_q;
  logic [3:0]          cnt_q [RESP_W];
  logic [3:0]          cnt_d [RESP_W];
  logic [RESP_W-1:0]   sync1_q, sync2_q;
  logic [C_LENGTH-1:0] lfsr_q, lfsr_step;
  logic [RESP_W-1:0]   maj;
  logic                stable_all;
  logic                phase_last;

  // Taps are chosen for the 8-stage chain; the register never leaves the nonzero cycle.
  assign lfsr_step  = {lfsr_q[C_LENGTH-2:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign phase_last = (phase_q == 4'(SETTLE - 1));
  assign ichallenge = lfsr_q;
  assign busy       = (state_q != IDLE);

  // Vote tallies including the sample being taken this cycle.
  always_comb begin
    maj        = '0;
    stable_all = 1'b1;
    for (int b = 0; b < RESP_W; b++) begin
      cnt_d[b]   = cnt_q[b] + {3'b000, sync2_q[b]};
      maj[b]     = (cnt_d[b] > 4'(NVOTE / 2));
      stable_all = stable_all & ((cnt_d[b] == 4'd0) || (cnt_d[b] == 4'(NVOTE)));
    end
  end

  always_comb begin
    // NOTE: default first, so every path through the case assigns state_d and no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE:    if (!seed_load && start) state_d = ARM;
      ARM:     if (phase_last) state_d = FIRE;
      FIRE:    if (phase_last) state_d = SAMPLE;
      SAMPLE:  state_d = (vote_q == 4'(NVOTE - 1)) ? OUT : RELAX;
      RELAX:   if (phase_last) state_d = FIRE;
      OUT:     if (ovalid && iready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      phase_q   <= '0;
      vote_q    <= '0;
      // NOTE: the vote counters are a handful of flops, not a RAM, so they take the reset too.
      for (int b = 0; b < RESP_W; b++) cnt_q[b] <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      lfsr_q    <= SEED_RST;
      opulse    <= 1'b0;
      ovalid    <= 1'b0;
      oresp     <= '0;
      ostable   <= 1'b0;
      ochal_tag <= '0;
    end else begin
      // NOTE: non-blocking throughout, so every flop samples the values from before the edge.
      state_q <= state_d;
      sync1_q <= iresponse;
      sync2_q <= sync1_q;
      opulse  <= (state_d == FIRE) || (state_d == SAMPLE);

      if (state_d != state_q)
        phase_q <= '0;
      else if (state_q == ARM || state_q == FIRE || state_q == RELAX)
        phase_q <= phase_q + 4'd1;

      case (state_q)
        IDLE: begin
          if (seed_load) begin
            lfsr_q <= (seed == '0) ? {{(C_LENGTH-1){1'b0}}, 1'b1} : seed;
          end else if (start) begin
            vote_q <= '0;
            for (int b = 0; b < RESP_W; b++) cnt_q[b] <= '0;
          end
        end
        SAMPLE: begin
          vote_q <= vote_q + 4'd1;
          for (int b = 0; b < RESP_W; b++) cnt_q[b] <= cnt_d[b];
          if (state_d == OUT) begin
            oresp     <= maj;
            ostable   <= stable_all;
            ochal_tag <= lfsr_q;
          end
        end
        OUT: begin
          if (ovalid && iready) begin
            ovalid <= 1'b0;
            lfsr_q <= lfsr_step;
          end else begin
            ovalid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Scoreboard bench for puf_challenge_sequencer: a per-excitation response
// driver, a majority-vote reference model and a decoupled output monitor.
module tb_puf_challenge_sequencer;

  localparam int NVOTE  = 5;
  localparam int SETTLE = 4;
  localparam int LAT    = SETTLE + NVOTE * (SETTLE + 1) + (NVOTE - 1) * SETTLE + 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       seed_load = 1'b0;
  logic       iready = 1'b0;
  logic [7:0] seed = '0;
  logic [7:0] ichallenge, ochal_tag;
  logic       opulse, ostable, ovalid, busy;
  logic [6:0] iresponse = '0;
  logic [6:0] oresp;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [6:0] resp;
    logic       stable;
    logic [7:0] tag;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [6:0] pat [NVOTE];
  int         pidx = 0;
  logic [7:0] lfsr_m;
  int         hs_count = 0;
  int         win_count = 0;
  int         valid_rises = 0;
  longint     t_start = 0;

  always #5 clk = ~clk;

  puf_challenge_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .seed_load  (seed_load),
    .seed       (seed),
    .ichallenge (ichallenge),
    .opulse     (opulse),
    .iresponse  (iresponse),
    .oresp      (oresp),
    .ostable    (ostable),
    .ochal_tag  (ochal_tag),
    .ovalid     (ovalid),
    .iready     (iready),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // Response driver: presents pat[k] to the PUF input for the k-th excitation.
  logic op_prev = 1'b0;
  always @(negedge clk) begin
    if (opulse && !op_prev && pidx < NVOTE) begin
      iresponse = pat[pidx];
      pidx++;
    end
    op_prev = opulse;
  end

  // Monitor: pulse windows, latency, valid width and scoreboard compare on handshake.
  int   win_len = 0;
  int   v_len = 0;
  logic v_prev = 1'b0;
  logic rdy_at_rise = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      win_len = 0;
      v_len   = 0;
      v_prev  = 1'b0;
    end else begin
      if (opulse) win_len++;
      else if (win_len != 0) begin
        check("pulse_window_len", win_len, SETTLE + 1);
        win_count++;
        win_len = 0;
      end
      if (ovalid && !v_prev) begin
        valid_rises++;
        check("start_to_valid_latency", int'(($time - 5 - t_start) / 10), LAT);
        check("valid_has_expectation", exp_q.size() != 0, 1);
        rdy_at_rise = iready;
        v_len = 0;
      end
      if (ovalid) v_len++;
      else if (v_prev && rdy_at_rise) check("valid_width_ready_high", v_len, 1);
      if (ovalid && iready) begin
        check("handshake_has_expectation", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("oresp", oresp, mon_e.resp);
          check("ostable", ostable, mon_e.stable);
          check("ochal_tag", ochal_tag, mon_e.tag);
        end
        hs_count++;
      end
      v_prev = ovalid;
    end
  end

  // Reference model: bitwise majority and unanimity over the excitation words.
  task automatic do_start();
    exp_t e;
    int   ones;
    e.tag    = lfsr_m;
    e.resp   = '0;
    e.stable = 1'b1;
    for (int b = 0; b < 7; b++) begin
      ones = 0;
      for (int k = 0; k < NVOTE; k++) ones += int'(pat[k][b]);
      e.resp[b] = (ones > NVOTE / 2);
      e.stable  = e.stable & ((ones == 0) || (ones == NVOTE));
    end
    exp_q.push_back(e);
    @(negedge clk);
    pidx  = 0;
    start = 1'b1;
    @(posedge clk);
    t_start = $time;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_hs(input int target);
    int n = 0;
    while (hs_count < target && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("handshake_within_budget", hs_count >= target, 1);
  endtask

  task automatic rand_pats();
    logic [6:0] w;
    w = 7'($urandom);
    for (int k = 0; k < NVOTE; k++) pat[k] = ($urandom_range(0, 3) == 0) ? w : 7'($urandom);
  endtask

  initial begin
    int   hs = 0;
    int   base;
    int   n;
    logic [6:0] held;

    for (int k = 0; k < NVOTE; k++) pat[k] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_opulse", opulse, 0);
    check("rst_ovalid", ovalid, 0);
    check("rst_oresp", oresp, 0);
    check("rst_ostable", ostable, 0);
    check("rst_ochal_tag", ochal_tag, 0);
    check("rst_busy", busy, 0);
    check("rst_lfsr", ichallenge, 8'hA5);
    lfsr_m = 8'hA5;

    // Constant 0x55 response, ready held high.
    for (int k = 0; k < NVOTE; k++) pat[k] = 7'h55;
    iready = 1'b1;
    base = win_count;
    do_start();
    hs++;
    wait_hs(hs);
    lfsr_m = lfsr_next(lfsr_m);
    @(negedge clk);
    check("pulse_window_count", win_count - base, NVOTE);
    check("ovalid_after_hs", ovalid, 0);
    check("busy_after_hs", busy, 0);
    check("lfsr_stepped_once", ichallenge, lfsr_m);

    // Split votes: bit0 1,0,1,0,1 and bit1 0,0,1,1,0.
    pat = '{7'h01, 7'h00, 7'h03, 7'h02, 7'h01};
    do_start();
    hs++;
    wait_hs(hs);
    lfsr_m = lfsr_next(lfsr_m);

    // Zero seed is replaced by 1.
    @(negedge clk);
    seed = 8'h00;
    seed_load = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    check("zero_seed_becomes_one", ichallenge, 8'h01);
    lfsr_m = 8'h01;
    rand_pats();
    do_start();
    hs++;
    wait_hs(hs);
    lfsr_m = lfsr_next(lfsr_m);
    @(negedge clk);
    check("lfsr_after_seed_one", ichallenge, lfsr_m);

    // seed_load wins over a simultaneous start.
    seed = 8'h3C;
    seed_load = 1'b1;
    start = 1'b1;
    @(negedge clk);
    seed_load = 1'b0;
    start = 1'b0;
    check("load_and_start_busy", busy, 0);
    check("load_and_start_lfsr", ichallenge, 8'h3C);
    @(negedge clk);
    check("load_and_start_still_idle", busy, 0);
    lfsr_m = 8'h3C;
    rand_pats();
    do_start();
    hs++;
    wait_hs(hs);
    lfsr_m = lfsr_next(lfsr_m);

    // Back-pressure: hold for 10 cycles, stray start ignored.
    iready = 1'b0;
    rand_pats();
    do_start();
    n = 0;
    while (!ovalid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("valid_seen_under_backpressure", ovalid, 1);
    held = oresp;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) start = 1'b1;
      if (i == 5) start = 1'b0;
      check("hold_ovalid", ovalid, 1);
      check("hold_oresp", oresp, held);
    end
    check("hold_busy", busy, 1);
    iready = 1'b1;
    hs++;
    wait_hs(hs);
    lfsr_m = lfsr_next(lfsr_m);
    @(negedge clk);
    check("release_busy", busy, 0);
    check("release_ovalid", ovalid, 0);
    check("release_lfsr", ichallenge, lfsr_m);

    // Reset during the third FIRE phase.
    rand_pats();
    do_start();
    n = 0;
    while (pidx < 3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("third_fire_reached", opulse, 1);
    #1 rst = 1'b1;
    #1;
    check("abort_opulse", opulse, 0);
    check("abort_busy", busy, 0);
    check("abort_ovalid", ovalid, 0);
    check("abort_lfsr", ichallenge, 8'hA5);
    void'(exp_q.pop_back());
    lfsr_m = 8'hA5;
    base = valid_rises;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    check("no_valid_after_abort", valid_rises, base);
    rand_pats();
    do_start();
    hs++;
    wait_hs(hs);
    lfsr_m = lfsr_next(lfsr_m);

    // Randomized back-to-back measurements.
    for (int t = 0; t < 8; t++) begin
      rand_pats();
      do_start();
      hs++;
      wait_hs(hs);
      lfsr_m = lfsr_next(lfsr_m);
    end
    @(negedge clk);
    check("final_lfsr", ichallenge, lfsr_m);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule

// File: doc/puf_challenge_sequencer.md
Name: puf_challenge_sequencer

Overview:
- Drives the arbiter PUF array: supplies the challenge word and the excitation pulse, then collects the 7-bit response.
- Fires each challenge NVOTE times and majority-votes each response bit.
- Presents the voted response with a valid/ready handshake and steps an LFSR to the next challenge.
- Sits directly upstream of the PUF (challenge and pulse) and directly downstream of it (response).

Parameters:
- C_LENGTH, 8: challenge width; equals the PUF mux-chain length.
- RESP_W, 7: PUF response width.
- NVOTE, 5: excitations per challenge. Must be odd, 1..15.
- SETTLE, 4: cycles per pulse phase (arm/high/low). Minimum 3, which covers the 2-flop synchronizer.
- SEED_RST, 8'hA5: LFSR value after reset.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: reset; one clock; reset is asynchronous and active-high.
- start, in, 1: begin a measurement. Accepted only in IDLE.
- seed_load, in, 1: load seed into the LFSR. Accepted only in IDLE.
- seed, in, C_LENGTH: LFSR load value. A value of 0 is replaced by 1.
- ichallenge, out, C_LENGTH: challenge to the PUF. Equals the LFSR, which is constant from start to handshake.
- opulse, out, 1: excitation pulse to the PUF, registered.
- iresponse, in, RESP_W: raw PUF response, asynchronous to clk.
- oresp, out, RESP_W: majority-voted response.
- ostable, out, 1: every response bit was unanimous across all NVOTE samples.
- ochal_tag, out, C_LENGTH: challenge that produced oresp.
- ovalid, out, 1: oresp, ostable and ochal_tag are valid.
- iready, in, 1: consumer accepts the result.
- busy, out, 1: state is not IDLE.

Behaviour:
- Reset values: state IDLE, LFSR=SEED_RST, opulse=0, ovalid=0, oresp=0, ostable=0, ochal_tag=0, busy=0. All counters and synchronizer flops are cleared.
- Reset asserted mid-operation aborts immediately. No result is produced and opulse drops at once.
- Synchronizer: iresponse passes through 2 flops; SAMPLE reads the second-stage value.
- FSM states: IDLE, ARM, FIRE, SAMPLE, RELAX, OUT.
  - IDLE: seed_load=1 loads the LFSR and has priority; a start in the same cycle is ignored. Otherwise start=1 clears the vote counters and moves to ARM.
  - ARM: opulse=0 for SETTLE cycles, then FIRE.
  - FIRE: opulse=1 for SETTLE cycles, then SAMPLE.
  - SAMPLE: 1 cycle with opulse=1. Per bit, cnt[b] increments when synced iresponse[b]=1, and the vote counter increments.
    - If votes reach NVOTE: register the results and go to OUT. oresp[b] = (cnt[b] > NVOTE/2). ostable=1 iff every cnt[b] is 0 or NVOTE. ochal_tag=LFSR.
    - Otherwise go to RELAX.
  - RELAX: opulse=0 for SETTLE cycles, then FIRE.
  - OUT: ovalid=1 and outputs are held stable. Handshake completes on the edge where ovalid and iready are both 1. On that edge: ovalid goes to 0, the LFSR steps once, and the state returns to IDLE.
- Latency: the state leaves IDLE on the edge that samples start. ovalid is high SETTLE + NVOTE*(SETTLE+1) + (NVOTE-1)*SETTLE + 1 cycles later, which is 46 with defaults.
- Counter widths are 4 bits, which is sufficient for NVOTE<=15.
- LFSR: Fibonacci, fb = q[7]^q[5]^q[4]^q[3], next = {q[6:0], fb}. It never reaches 0 from a nonzero state. It steps only on the handshake.
- start, seed_load or seed changes while busy have no effect.
- iready while not in OUT has no effect.
- iready held high before OUT: the handshake completes in the first OUT cycle, so ovalid is high for exactly 1 cycle.
- Back-to-back operation: start may be asserted in the cycle after the handshake. The new measurement uses the stepped LFSR.

Test Plan:
- Reset, then start with iresponse=7'h55 held, iready=1 → opulse shows 5 high windows of 5 cycles (4 FIRE + 1 SAMPLE). ovalid is a 1-cycle pulse 46 cycles after the start edge with oresp=7'h55, ostable=1, ochal_tag=8'hA5. After the handshake, ichallenge=8'h4A.
- Bit 0 toggles per excitation 1,0,1,0,1 and bit 1 follows 0,0,1,1,0; other bits held 0 → oresp=7'h01, ostable=0.
- seed_load=1 with seed=8'h00 in IDLE → ichallenge=8'h01. After one completed measurement, ichallenge=8'h02.
- seed_load and start in the same cycle with seed=8'h3C → LFSR=8'h3C and busy stays 0. A later start measures with ochal_tag=8'h3C.
- iready=0 for 10 cycles after ovalid rises → ovalid and oresp hold. A start pulse during the wait is ignored. Raising iready completes the handshake and returns to IDLE.
- rst asserted in the 3rd FIRE phase → opulse=0 and busy=0 immediately, with no ovalid. The LFSR returns to 8'hA5, and a later start completes normally.
